// File: rtl/add_arb_pkg.sv
// Shared types and helpers for the shared-adder arbiter.
// Holds the FSM state enum, default sizing constants and the round-robin pick.
// The pick function is purely combinational and supports up to 8 requesters.
package add_arb_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 32;
  localparam int RR_MAX    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // One-hot pick of the first valid requester at or above ptr, wrapping at n.
  function automatic logic [RR_MAX-1:0] rr_next(
    input logic [RR_MAX-1:0] valid,
    input logic [2:0]        ptr,
    input int unsigned       n
  );
    logic [RR_MAX-1:0] grant;
    logic              found;
    int unsigned       idx;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < RR_MAX; k++) begin
      if (k < n) begin
        idx = (32'(ptr) + k) % n;
        if (!found && valid[idx[2:0]]) begin
          grant[idx[2:0]] = 1'b1;
          found           = 1'b1;
        end
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/add_unit.sv
// Combinational WIDTH-bit adder shared by all requesters.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the owning FSM decides when the result is captured.
module add_unit #(
  parameter int WIDTH    = 32,
  parameter bit CARRY_EN = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  generate
    if (CARRY_EN) begin : g_carry
      logic [WIDTH:0] full;
      // Widened add so the carry-out is kept as the top bit.
      assign full  = {1'b0, a} + {1'b0, b};
      assign sum   = full[WIDTH-1:0];
      assign carry = full[WIDTH];
    end else begin : g_nocarry
      // Plain modular add; overflow is intentionally dropped.
      assign sum   = a + b;
      assign carry = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/add_share_arbiter.sv
// Round-robin arbiter sharing one adder among N_REQ requesters; optional carry-out via ADD_ARB_CARRY_EN.
// Latency: request accepted at the end of the grant cycle, response valid two clock edges later.
// Backpressure: rsp_ready low holds DONE with stable outputs; no requester is granted until the response is taken.
module add_share_arbiter
  import add_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
`ifdef ADD_ARB_CARRY_EN
  output logic                   rsp_carry,
`endif
  output logic [WIDTH-1:0]       rsp_sum
);

`ifdef ADD_ARB_CARRY_EN
  localparam bit CARRY_EN = 1'b1;
`else
  localparam bit CARRY_EN = 1'b0;
`endif

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   op_id;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic [WIDTH-1:0]  add_sum;
  logic              add_carry;

  logic [RR_MAX-1:0] valid_ext;
  logic [RR_MAX-1:0] grant_ext;
  logic [2:0]        ptr_ext;
  logic              unused_grant;

  logic [ID_W-1:0]   sel_idx;
  logic [WIDTH-1:0]  sel_a;
  logic [WIDTH-1:0]  sel_b;
  logic              accept;

  // Round-robin grant, only offered while idle so a busy datapath never accepts.
  always_comb begin
    valid_ext               = '0;
    valid_ext[N_REQ-1:0]    = req_valid;
    ptr_ext                 = '0;
    ptr_ext[ID_W-1:0]       = rr_ptr;
    grant_ext               = rr_next(valid_ext, ptr_ext, N_REQ);
    req_ready               = (state == IDLE) ? grant_ext[N_REQ-1:0] : '0;
  end

  // Bits above N_REQ are always zero from rr_next.
  assign unused_grant = ^grant_ext;

  // Decode the one-hot grant into an index and the granted operand pair.
  always_comb begin
    sel_idx = '0;
    sel_a   = '0;
    sel_b   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_ready[i]) begin
        sel_idx = ID_W'(i);
        sel_a   = req_a[i*WIDTH +: WIDTH];
        sel_b   = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign accept = |req_ready;

  add_unit #(
    .WIDTH    (WIDTH),
    .CARRY_EN (CARRY_EN)
  ) u_add (
    .a     (op_a),
    .b     (op_b),
    .sum   (add_sum),
    .carry (add_carry)
  );

`ifndef ADD_ARB_CARRY_EN
  logic unused_carry;
  assign unused_carry = add_carry;
`endif

  // Transaction FSM: latch operands on accept, register the sum, hold until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      op_id     <= '0;
      op_a      <= '0;
      op_b      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
`ifdef ADD_ARB_CARRY_EN
      rsp_carry <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_a   <= sel_a;
            op_b   <= sel_b;
            op_id  <= sel_idx;
            rr_ptr <= (sel_idx == ID_W'(N_REQ - 1)) ? '0 : sel_idx + 1'b1;
            state  <= BUSY;
          end
        end
        BUSY: begin
          rsp_sum   <= add_sum;
          rsp_id    <= op_id;
`ifdef ADD_ARB_CARRY_EN
          rsp_carry <= add_carry;
`endif
          rsp_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_share_arbiter.sv
// Directed bench for add_share_arbiter with a response scoreboard.
// Expected responses are queued when a grant is observed and checked on each response handshake.
// Carry checks are compiled in only when ADD_ARB_CARRY_EN is defined.
module tb_add_share_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_a;
  logic [N*W-1:0]  req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [W-1:0]    rsp_sum;
`ifdef ADD_ARB_CARRY_EN
  logic            rsp_carry;
`endif

  logic [W-1:0] a_arr [N];
  logic [W-1:0] b_arr [N];

  typedef struct packed {
    logic [IW-1:0] id;
    logic [W-1:0]  sum;
    logic          carry;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  add_share_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
`ifdef ADD_ARB_CARRY_EN
    .rsp_carry (rsp_carry),
`endif
    .rsp_sum   (rsp_sum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = a_arr[i];
      req_b[i*W +: W] = b_arr[i];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare every response handshake against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'(rsp_valid), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_id", 64'(rsp_id), 64'(mon_e.id));
        check("rsp_sum", 64'(rsp_sum), 64'(mon_e.sum));
`ifdef ADD_ARB_CARRY_EN
        check("rsp_carry", 64'(rsp_carry), 64'(mon_e.carry));
`endif
      end
    end
  end

  // Wait (bounded) for a grant, check it is the expected requester, queue its result.
  task automatic wait_grant(input string tag, input int idx, output int gcyc);
    int n;
    logic [W:0] s;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (req_ready == '0 && n < 12) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(req_ready), 64'(4'(1) << idx));
    s       = {1'b0, a_arr[idx]} + {1'b0, b_arr[idx]};
    e.id    = IW'(idx);
    e.sum   = s[W-1:0];
    e.carry = s[W];
    exp_q.push_back(e);
    gcyc = cyc;
  endtask

  // Bounded wait for all queued responses, then realign just after a rising edge.
  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_rst_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_rst_rsp_id"}, 64'(rsp_id), 64'd0);
    check({tag, "_rst_rsp_sum"}, 64'(rsp_sum), 64'd0);
    check({tag, "_rst_req_ready"}, 64'(req_ready), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int g_prev;
    int g_cur;
    int order [5];
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      a_arr[i] = '0;
      b_arr[i] = '0;
    end
    order = '{0, 1, 2, 3, 0};

    do_reset("por");

    // Single request: grant visible same cycle, response two edges after accept.
    a_arr[0]  = 32'h0;
    b_arr[0]  = 32'h1;
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    wait_grant("t1_grant", 0, g_cur);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    check("t1_busy_rsp_valid", 64'(rsp_valid), 64'd0);
    check("t1_busy_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    check("t1_done_rsp_valid", 64'(rsp_valid), 64'd1);
    check("t1_done_rsp_sum", 64'(rsp_sum), 64'h1);
    @(posedge clk); #1;
    check("t1_idle_rsp_valid", 64'(rsp_valid), 64'd0);
    check("t1_drained", 64'(exp_q.size()), 64'd0);

    // Two simultaneous requesters from rr_ptr=0.
    do_reset("t2");
    a_arr[0]  = 32'h1;
    b_arr[0]  = 32'h2;
    a_arr[1]  = 32'hFFFF;
    b_arr[1]  = 32'h0;
    req_valid = 4'b0011;
    wait_grant("t2_grant0", 0, g_cur);
    wait_grant("t2_grant1", 1, g_cur);
    @(posedge clk); #1;
    req_valid = '0;
    drain("t2_drain");

    // All four valid continuously: order 0,1,2,3,0 at one grant per 3 cycles.
    do_reset("t3");
    for (int i = 0; i < N; i++) begin
      a_arr[i] = 32'h0100_0000 * 32'(i + 1);
      b_arr[i] = 32'h11 * 32'(i + 3);
    end
    req_valid = 4'b1111;
    g_prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_grant("t3_grant", order[k], g_cur);
      if (k > 0) check("t3_gap", 64'(g_cur - g_prev), 64'd3);
      g_prev = g_cur;
    end
    @(posedge clk); #1;
    req_valid = '0;
    drain("t3_drain");

    // Overflow cases (rr_ptr is now 1, so requester 2 then 3 are picked).
    a_arr[2]  = 32'hFFFF_FFFF;
    b_arr[2]  = 32'h1;
    req_valid = 4'b0100;
    wait_grant("t4_grant2", 2, g_cur);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    check("t4_ovf_sum", 64'(rsp_sum), 64'h0);
`ifdef ADD_ARB_CARRY_EN
    check("t4_ovf_carry", 64'(rsp_carry), 64'd1);
`endif
    @(posedge clk); #1;
    a_arr[3]  = 32'h0000_FFFF;
    b_arr[3]  = 32'h0002_CCC1;
    req_valid = 4'b1000;
    wait_grant("t4_grant3", 3, g_cur);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    check("t4_wide_sum", 64'(rsp_sum), 64'h0003_CCC0);
    @(posedge clk); #1;
    check("t4_drained", 64'(exp_q.size()), 64'd0);

    // Backpressure: hold DONE for 5 cycles while another requester waits.
    rsp_ready = 1'b0;
    a_arr[0]  = 32'h5;
    b_arr[0]  = 32'h7;
    a_arr[1]  = 32'h10;
    b_arr[1]  = 32'h20;
    req_valid = 4'b0011;
    wait_grant("t5_grant0", 0, g_cur);
    @(posedge clk); #1;
    req_valid = 4'b0010;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t5_hold_valid", 64'(rsp_valid), 64'd1);
      check("t5_hold_id", 64'(rsp_id), 64'd0);
      check("t5_hold_sum", 64'(rsp_sum), 64'hC);
      check("t5_hold_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("t5_release_rsp_valid", 64'(rsp_valid), 64'd0);
    check("t5_release_req_ready", 64'(req_ready), 64'b0010);
    wait_grant("t5_grant1", 1, g_cur);
    @(posedge clk); #1;
    req_valid = '0;
    drain("t5_drain");

    // Reset during BUSY aborts the transaction and clears rr_ptr.
    a_arr[2]  = 32'h3;
    b_arr[2]  = 32'h4;
    req_valid = 4'b0100;
    @(negedge clk);
    check("t6_grant2", 64'(req_ready), 64'b0100);
    @(posedge clk); #1;
    req_valid = '0;
    rst_n     = 1'b0;
    #1;
    check("t6_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("t6_rst_rsp_id", 64'(rsp_id), 64'd0);
    check("t6_rst_rsp_sum", 64'(rsp_sum), 64'd0);
    check("t6_rst_req_ready", 64'(req_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t6_no_replay", 64'(rsp_valid), 64'd0);
    end
    @(posedge clk); #1;
    a_arr[0]  = 32'h9;
    b_arr[0]  = 32'h1;
    a_arr[3]  = 32'h77;
    b_arr[3]  = 32'h1;
    req_valid = 4'b1001;
    wait_grant("t6_ptr_zero", 0, g_cur);
    @(posedge clk); #1;
    req_valid = '0;
    drain("t6_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
